// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-timing helper.
// The TX and RX blocks both import this package.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_t;

    // Clock cycles per line bit. Integer division truncates toward zero.
    function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage

// File: rtl/uart_tx_byte_fifo.sv
// Circular byte FIFO with occupancy count. DEPTH must be a power of two.
// Push while full and pop while empty are ignored.
module uart_tx_byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter (start, LSB-first data, stop bits) fed by a byte FIFO.
// Define UART_TX_BREAK_EN to add the send_break input and the BREAK state.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int BIT_RATE     = 9600,
    parameter int CLK_HZ       = 50_000_000,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          uart_tx_en,
    input  logic                          tx_valid,
    input  logic [PAYLOAD_BITS-1:0]       tx_data,
`ifdef UART_TX_BREAK_EN
    input  logic                          send_break,
`endif
    output logic                          tx_ready,
    output logic                          uart_txd,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CPB        = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int CYC_W      = $clog2(CPB + 1);
    localparam int BREAK_BITS = PAYLOAD_BITS + STOP_BITS + 1;
    localparam int BIT_W      = $clog2(BREAK_BITS + 1);

    uart_state_t             state;
    logic [CYC_W-1:0]        cyc_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic [PAYLOAD_BITS-1:0] shift_reg;
    logic [PAYLOAD_BITS-1:0] fifo_head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_pop;
    logic                    bit_end;
    logic                    stop_end;
    logic                    can_start;
    logic                    break_req;

    uart_tx_byte_fifo #(
        .WIDTH (PAYLOAD_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (tx_valid),
        .pop     (fifo_pop),
        .wr_data (tx_data),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign tx_ready  = !fifo_full;
    assign tx_busy   = (state != IDLE) || !fifo_empty;
    assign bit_end   = (cyc_cnt == CYC_W'(CPB - 1));
    assign stop_end  = bit_end && (bit_cnt == BIT_W'(STOP_BITS - 1));
    assign can_start = uart_tx_en && !fifo_empty;

`ifdef UART_TX_BREAK_EN
    assign break_req = send_break;
`else
    assign break_req = 1'b0;
`endif

    // Pop in the same cycle the FSM loads the shift register.
    always_comb begin
        fifo_pop = 1'b0;
        if (state == IDLE) begin
            fifo_pop = can_start && !break_req;
        end else if (state == STOP) begin
            fifo_pop = can_start && stop_end;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            uart_txd <= 1'b1;
            cyc_cnt  <= '0;
            bit_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cyc_cnt <= '0;
                    bit_cnt <= '0;
                    if (break_req) begin
                        state    <= BREAK;
                        uart_txd <= 1'b0;
                    end else if (can_start) begin
                        state     <= START;
                        uart_txd  <= 1'b0;
                        shift_reg <= fifo_head;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cyc_cnt   <= '0;
                        bit_cnt   <= '0;
                        state     <= DATA;
                        uart_txd  <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        if (bit_cnt == BIT_W'(PAYLOAD_BITS - 1)) begin
                            bit_cnt  <= '0;
                            state    <= STOP;
                            uart_txd <= 1'b1;
                        end else begin
                            bit_cnt   <= bit_cnt + 1'b1;
                            uart_txd  <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        if (stop_end) begin
                            bit_cnt <= '0;
                            // Chain straight into the next start bit when data is waiting.
                            if (can_start) begin
                                state     <= START;
                                uart_txd  <= 1'b0;
                                shift_reg <= fifo_head;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_BREAK_EN
                BREAK: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        if (bit_cnt == BIT_W'(BREAK_BITS - 1)) begin
                            bit_cnt  <= '0;
                            state    <= IDLE;
                            uart_txd <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    state    <= IDLE;
                    uart_txd <= 1'b1;
                    cyc_cnt  <= '0;
                    bit_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter BIT_RATE, default 9600: line bit rate in baud.
REQ-002 SHALL have parameter CLK_HZ, default 50_000_000: clk frequency in Hz.
REQ-003 SHALL have parameter PAYLOAD_BITS, default 8: data bits per frame.
REQ-004 SHALL have parameter STOP_BITS, default 1: stop bits per frame (1 or 2).
REQ-005 SHALL have parameter FIFO_DEPTH, default 16: byte FIFO entries; power of two, at least 2.
REQ-006 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port uart_tx_en, input, 1: when low, no new frame starts; the FIFO still accepts data.
REQ-009 SHALL have port tx_valid, input, 1: write request.
REQ-010 SHALL have port tx_data, input, PAYLOAD_BITS: byte to send.
REQ-011 SHALL have port tx_ready, output, 1: FIFO not full.
REQ-012 SHALL have port uart_txd, output, 1: serial line, idle high.
REQ-013 SHALL have port tx_busy, output, 1: a frame is in progress, or the FIFO is non-empty.
REQ-014 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1: current occupancy.

Function
REQ-015 SHALL derive CYCLES_PER_BIT = CLK_HZ/BIT_RATE by integer division (5208 at the defaults), and every bit SHALL last exactly CYCLES_PER_BIT cycles.
REQ-016 SHALL accept tx_data into the FIFO tail on any cycle with tx_valid && tx_ready; tx_valid while full SHALL be ignored, with no overwrite and no error.
REQ-017 SHALL use FSM states IDLE, START, DATA, STOP.
REQ-018 IDLE->START SHALL occur when the FIFO is non-empty and uart_tx_en=1; in that cycle the head entry is popped into the shift register and uart_txd drives 0 from the next cycle.
REQ-019 START->DATA SHALL occur after 1 bit period; DATA SHALL send PAYLOAD_BITS bits LSB first; DATA->STOP SHALL occur after the last bit.
REQ-020 STOP SHALL drive 1 for STOP_BITS bit periods, then go to IDLE, or go directly to START when the FIFO is non-empty and uart_tx_en=1, giving back-to-back frames with no idle gap.
REQ-021 Push and pop in the same cycle SHALL leave fifo_count unchanged; a push into an empty FIFO is eligible for a pop no earlier than the next cycle.
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full = (count==FIFO_DEPTH); empty = (count==0).
REQ-023 Deasserting uart_tx_en mid-frame SHALL NOT truncate the current frame; it only blocks the next START.
REQ-024 uart_txd SHALL be driven from a register (glitch-free).

Reset
REQ-025 On reset=1 at a clk edge: state=IDLE, uart_txd=1, FIFO emptied (fifo_count=0), tx_ready=1, tx_busy=0, bit and cycle counters cleared.
REQ-026 Reset mid-frame SHALL abort the frame, raise uart_txd to 1 on the next cycle, and discard all FIFO contents.

Configuration
REQ-027 Macro UART_TX_BREAK_EN SHALL, when defined, add input send_break (1 bit); a send_break pulse seen while in IDLE holds uart_txd=0 for (PAYLOAD_BITS+STOP_BITS+1) bit periods in an extra FSM state BREAK, then returns to IDLE; FIFO pops are suppressed during BREAK; tx_busy=1 during BREAK.
REQ-028 Without UART_TX_BREAK_EN, the send_break port and the BREAK state SHALL be absent, and behaviour SHALL be exactly per REQ-015..026.

Structure
REQ-029 Package uart_pkg SHALL hold the FSM state enum (IDLE, START, DATA, STOP, BREAK) and a function computing CYCLES_PER_BIT; uart_rx users SHALL import the same package.
REQ-030 The FIFO SHALL be a separate sub-module, uart_tx_byte_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count).

Verification
REQ-031 Push 0x41 at the default parameters -> uart_txd low for 5208 cycles, then 1,0,0,0,0,0,1,0 at 5208 cycles each, then high for 5208 cycles; the co-sim uart_rx reports 0x41.
REQ-032 Push "Hi\n" (0x48, 0x69, 0x0A) in 3 consecutive cycles -> three back-to-back frames (30 bit periods total, no gap); the downstream logger prints "TB_UART:Hi".
REQ-033 Push 17 bytes on consecutive cycles with uart_tx_en=0 -> tx_ready falls after the 16th, the 17th is dropped, fifo_count=16; raise uart_tx_en -> exactly 16 frames, fifo_count returns to 0.
REQ-034 Assert reset for 1 cycle during DATA bit 3 of 0xA5 -> uart_txd=1 from the next cycle, fifo_count=0, tx_busy=0; a later push of 0x5A is sent intact.
REQ-035 With UART_TX_BREAK_EN, pulse send_break in IDLE -> uart_txd=0 for 10 x 5208 cycles; the downstream uart_rx asserts uart_rx_break; a byte queued during the break is sent after it ends.
REQ-036 Push while popping at fifo_count=1 across a pointer wrap (after 15 prior frames) -> fifo_count stays 1 and data order is preserved.
